// File: rtl/uart_rx_ctrl_if.sv
// Bundles the serial-line input, baud strobe, receiver strobes and frame results
// for uart_rx_ctrl.
//   master : drives Baud_Tick and Rx_Serial and observes the results (bench or host side).
//   slave  : receiver side (uart_rx_ctrl).
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 Baud_Tick;
  logic                 Rx_Serial;
  logic                 DeStart_Bit;
  logic                 Shift1;
  logic                 Check_Stop;
  logic                 Load1;
  logic [DATA_BITS-1:0] Rx_dataOut;
  logic                 Parity_Error;
  logic                 Stop_Error;
  logic                 Busy;

  modport master (
    output Baud_Tick, Rx_Serial,
    input  DeStart_Bit, Shift1, Check_Stop, Load1, Rx_dataOut, Parity_Error, Stop_Error, Busy
  );

  modport slave (
    input  Baud_Tick, Rx_Serial,
    output DeStart_Bit, Shift1, Check_Stop, Load1, Rx_dataOut, Parity_Error, Stop_Error, Busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start-bit detection with glitch rejection,
// LSB-first data capture, optional parity check, stop-bit check and break handling.
// Ports:
//   Clock_In : system clock, all state changes on its rising edge
//   Reset    : synchronous, active-low reset
//   bus      : uart_rx_ctrl_if slave modport
//              in : Baud_Tick (OVERSAMPLE x baud strobe), Rx_Serial (async line, idle high)
//              out: DeStart_Bit, Shift1, Check_Stop, Load1 (one-cycle strobes),
//                   Rx_dataOut, Parity_Error, Stop_Error (held between loads), Busy
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic           Clock_In,
  input logic           Reset,
  uart_rx_ctrl_if.slave bus
);

  localparam int unsigned TickW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
  localparam logic             OddBit   = (PARITY_ODD != 0);
  localparam logic             ParOn    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TickW-1:0]     tick_q;
  logic [BitW-1:0]      bit_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_err_q;

  logic                 de_q;
  logic                 shift_q;
  logic                 stop_q;
  logic                 load_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 perr_q;
  logic                 serr_q;

  assign rx_s = sync_q[1];

  always_ff @(posedge Clock_In) begin
    if (!Reset) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      tick_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      de_q      <= 1'b0;
      shift_q   <= 1'b0;
      stop_q    <= 1'b0;
      load_q    <= 1'b0;
      dout_q    <= '0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.Rx_Serial};
      de_q    <= 1'b0;
      shift_q <= 1'b0;
      stop_q  <= 1'b0;
      load_q  <= 1'b0;
      if (bus.Baud_Tick) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s) begin
              state_q <= StStart;
              tick_q  <= '0;
            end
          end
          StStart: begin
            // Re-check the line at mid start bit; a high line here was a glitch.
            if (tick_q == TickMid) begin
              tick_q <= '0;
              bit_q  <= '0;
              if (!rx_s) begin
                de_q    <= 1'b1;
                state_q <= StData;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StData: begin
            if (tick_q == TickLast) begin
              tick_q  <= '0;
              // LSB arrives first, so shifting in at the MSB end leaves it at bit 0.
              data_q  <= {rx_s, data_q[DATA_BITS-1:1]};
              shift_q <= 1'b1;
              bit_q   <= bit_q + 1'b1;
              if (bit_q == BitLast) begin
                state_q <= ParOn ? StParity : StStop;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StParity: begin
            if (tick_q == TickLast) begin
              tick_q    <= '0;
              par_err_q <= (^data_q) ^ rx_s ^ OddBit;
              state_q   <= StStop;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StStop: begin
            if (tick_q == TickLast) begin
              tick_q  <= '0;
              stop_q  <= 1'b1;
              load_q  <= 1'b1;
              dout_q  <= data_q;
              perr_q  <= ParOn ? par_err_q : 1'b0;
              serr_q  <= ~rx_s;
              // A low stop bit is treated as the start of a break condition.
              state_q <= rx_s ? StIdle : StBreak;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StBreak: begin
            if (rx_s) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.DeStart_Bit  = de_q;
  assign bus.Shift1       = shift_q;
  assign bus.Check_Stop   = stop_q;
  assign bus.Load1        = load_q;
  assign bus.Rx_dataOut   = dout_q;
  assign bus.Parity_Error = perr_q;
  assign bus.Stop_Error   = serr_q;
  assign bus.Busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (8 data bits, even parity, 16x oversampling).
module tb_uart_rx_ctrl;

  localparam int unsigned DB      = 8;
  localparam int unsigned OS      = 16;
  localparam int          LATENCY = 168;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_rx_ctrl #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .Clock_In(clk),
    .Reset   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    int         det_tick;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;
    logic       perr;
  } vec_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         tick_no = 0;
  int         n_de = 0;
  int         n_shift = 0;
  int         n_stop = 0;
  int         n_load = 0;
  logic [7:0] model_out = 8'h00;
  logic       model_perr = 1'b0;
  logic       model_serr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Hold the line at v for n baud-tick periods (4 clocks each, tick on the last clock).
  task automatic send_level(input logic v, input int n);
    bus.Rx_Serial = v;
    repeat (n) begin
      bus.Baud_Tick = 1'b0;
      repeat (3) @(negedge clk);
      bus.Baud_Tick = 1'b1;
      @(negedge clk);
    end
    bus.Baud_Tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit,
                            input int stop_ticks, input logic exp_perr, input logic exp_serr);
    exp_t e;
    e.data     = d;
    e.perr     = exp_perr;
    e.serr     = exp_serr;
    e.det_tick = tick_no + 1;
    sb.push_back(e);
    send_level(1'b0, OS);
    for (int i = 0; i < DB; i++) send_level(d[i], OS);
    send_level(par, OS);
    send_level(stop_bit, stop_ticks);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {bus.DeStart_Bit, bus.Shift1, bus.Check_Stop, bus.Load1}, 4'h0);
    check({tag, "_dataout"}, bus.Rx_dataOut, 8'h00);
    check({tag, "_flags"}, {bus.Parity_Error, bus.Stop_Error}, 2'b00);
    check({tag, "_busy"}, bus.Busy, 1'b0);
  endtask

  // Monitor: sample just after each rising edge, count strobes, score completed frames.
  initial begin
    int   excl;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        model_out  = 8'h00;
        model_perr = 1'b0;
        model_serr = 1'b0;
      end
      if (bus.Baud_Tick) tick_no++;
      excl = int'(bus.DeStart_Bit) + int'(bus.Shift1) + int'(bus.Check_Stop | bus.Load1);
      if (excl != 0) begin
        check("strobe_exclusive", (excl > 1), 1'b0);
        check("stop_with_load", bus.Check_Stop, bus.Load1);
      end
      if (bus.DeStart_Bit) n_de++;
      if (bus.Shift1) n_shift++;
      if (bus.Check_Stop) n_stop++;
      if (bus.Load1) begin
        n_load++;
        check("load_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rx_dataout", bus.Rx_dataOut, e.data);
          check("parity_error", bus.Parity_Error, e.perr);
          check("stop_error", bus.Stop_Error, e.serr);
          check("load_latency", tick_no - e.det_tick, LATENCY);
          model_out  = e.data;
          model_perr = e.perr;
          model_serr = e.serr;
        end
      end else if (bus.Baud_Tick) begin
        check("dataout_hold", {bus.Rx_dataOut, bus.Parity_Error, bus.Stop_Error},
              {model_out, model_perr, model_serr});
      end
    end
  end

  initial begin
    vec_t vt[8];
    int   de0, sh0, ld0, st0;

    vt[0] = '{8'hA5, 1'b0, 3, 1'b0};
    vt[1] = '{8'h3C, 1'b1, 3, 1'b1};
    vt[2] = '{8'h01, 1'b1, 3, 1'b0};
    vt[3] = '{8'h80, 1'b0, 3, 1'b1};
    vt[4] = '{8'h00, 1'b0, 0, 1'b0};
    vt[5] = '{8'hFF, 1'b0, 0, 1'b0};
    vt[6] = '{8'h5A, 1'b0, 3, 1'b0};
    vt[7] = '{8'h07, 1'b1, 3, 1'b0};

    bus.Baud_Tick = 1'b0;
    bus.Rx_Serial = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    send_level(1'b1, 4);

    // Table of frames; entries 4 and 5 run back-to-back with no idle gap.
    for (int k = 0; k < 8; k++) begin
      de0 = n_de; sh0 = n_shift; ld0 = n_load; st0 = n_stop;
      send_frame(vt[k].data, vt[k].par, 1'b1, OS, vt[k].perr, 1'b0);
      send_level(1'b1, vt[k].gap);
      check("destart_count", n_de - de0, 1);
      check("shift_count", n_shift - sh0, DB);
      check("load_count", n_load - ld0, 1);
      check("check_stop_count", n_stop - st0, 1);
      if (vt[k].gap > 0) check("idle_after_frame", bus.Busy, 1'b0);
    end

    // Short low glitch in idle is rejected at mid start bit.
    de0 = n_de;
    send_level(1'b0, 4);
    check("glitch_busy_start", bus.Busy, 1'b1);
    send_level(1'b1, 5);
    check("glitch_busy_idle", bus.Busy, 1'b0);
    check("glitch_no_destart", n_de - de0, 0);

    // Low stop bit followed by a held-low line: stop error, single load, break until high.
    ld0 = n_load;
    send_frame(8'h55, 1'b0, 1'b0, 40, 1'b0, 1'b1);
    check("break_busy", bus.Busy, 1'b1);
    check("break_single_load", n_load - ld0, 1);
    send_level(1'b1, 2);
    check("break_exit_idle", bus.Busy, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, OS, 1'b0, 1'b0);
    send_level(1'b1, 3);
    check("after_break_load", n_load - ld0, 2);

    // Reset after the 4th data bit of 0x81 aborts the frame.
    sh0 = n_shift; ld0 = n_load;
    send_level(1'b0, OS);
    for (int i = 0; i < 4; i++) send_level(i == 0, OS);
    check("abort_shift_count", n_shift - sh0, 4);
    check("abort_busy", bus.Busy, 1'b1);
    rst_n = 1'b0;
    bus.Rx_Serial = 1'b1;
    bus.Baud_Tick = 1'b1;
    @(negedge clk);
    bus.Baud_Tick = 1'b0;
    @(negedge clk);
    check_all_zero("midframe_reset");
    rst_n = 1'b1;
    send_level(1'b1, 20);
    check("abort_no_load", n_load - ld0, 0);
    send_frame(8'h7E, 1'b0, 1'b1, OS, 1'b0, 1'b0);
    send_level(1'b1, 3);
    check("restart_load", n_load - ld0, 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame (5..8), LSB first.
REQ-002 Parameter OVERSAMPLE, default 16, Baud_Tick pulses per bit period.
REQ-003 Parameter PARITY_EN, default 1, 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-005 Clock_In  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-006 Reset  input  1  synchronous, active-low reset.
REQ-007 Baud_Tick  input  1  one-cycle strobe at OVERSAMPLE x baud rate.
REQ-008 Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-009 DeStart_Bit  output  1  one-cycle pulse when a start bit is confirmed at mid-bit.
REQ-010 Shift1  output  1  one-cycle pulse per data bit sampled into Rx_data.
REQ-011 Check_Stop  output  1  one-cycle pulse when the stop bit is sampled.
REQ-012 Load1  output  1  one-cycle pulse when a completed frame is loaded to Rx_dataOut.
REQ-013 Rx_dataOut  output  DATA_BITS  last completed frame, held until the next Load1.
REQ-014 Parity_Error  output  1  parity mismatch of the last frame, updated only with Load1.
REQ-015 Stop_Error  output  1  stop bit sampled low in the last frame, updated only with Load1.
REQ-016 Busy  output  1  high in every state except IDLE.

Function
REQ-017 Rx_Serial SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and BREAK; the tick and bit counters advance only in cycles with Baud_Tick=1.
REQ-019 IDLE: synchronized line low on a Baud_Tick -> START; tick counter cleared to 0.
REQ-020 START: on the tick where the counter reaches OVERSAMPLE/2-1, line low -> pulse DeStart_Bit, clear tick and bit counters, go to DATA; line high -> IDLE with no pulse (glitch rejection).
REQ-021 DATA: on every OVERSAMPLE-th tick, sample the line, shift it into Rx_data at the MSB end (LSB first on the wire), pulse Shift1, and increment the bit counter; after DATA_BITS samples -> PARITY if PARITY_EN=1, else STOP.
REQ-022 PARITY: on the OVERSAMPLE-th tick, sample the parity bit; error = (XOR of data bits XOR parity bit XOR PARITY_ODD) != 0; -> STOP.
REQ-023 STOP: on the OVERSAMPLE-th tick, pulse Check_Stop and Load1 in the same cycle; Rx_dataOut, Parity_Error and Stop_Error update in that cycle; line high -> IDLE, line low -> BREAK.
REQ-024 BREAK: remain until the synchronized line is high on a Baud_Tick, then -> IDLE; no strobes are issued.
REQ-025 With PARITY_EN=0, Parity_Error SHALL be loaded as 0.
REQ-026 DeStart_Bit, Shift1, Check_Stop and Load1 are registered one-cycle pulses and are mutually exclusive in any cycle.
REQ-027 Latency: Load1 rises exactly (OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+PARITY_EN+1)) Baud_Ticks after the tick that detected the falling edge.
REQ-028 The Rx_data shift register is internal; Rx_dataOut changes only on Load1.

Reset
REQ-029 Reset=0 at a clock edge SHALL force IDLE, clear all counters and the synchronizer to 1, and drive all outputs to 0, including Rx_dataOut.
REQ-030 Reset asserted mid-frame aborts the frame with no Load1; reception restarts on the next falling edge after Reset=1.
REQ-031 Reset takes priority over Baud_Tick in the same cycle.

Verification
REQ-032 8E1, byte 0xA5 (even parity bit 0, stop 1) -> DeStart_Bit x1, Shift1 x8, Check_Stop and Load1 in the same cycle, Rx_dataOut=0xA5, Parity_Error=0, Stop_Error=0; Load1 occurs 168 ticks after the edge.
REQ-033 Byte 0x3C sent with parity bit 1 -> Load1 with Rx_dataOut=0x3C, Parity_Error=1; next correct frame 0x01 -> Parity_Error=0.
REQ-034 Low glitch of 4 ticks in IDLE -> no DeStart_Bit, FSM back in IDLE, Busy low within 8 ticks.
REQ-035 Frame 0x55 with stop bit low and the line held low 40 ticks -> Stop_Error=1, Load1 once, FSM in BREAK until the line goes high, then the next frame 0xFF is received correctly.
REQ-036 Reset=0 after the 4th Shift1 of frame 0x81 -> all outputs 0, no Load1; after release, frame 0x7E -> Rx_dataOut=0x7E.
REQ-037 Back-to-back frames 0x00, 0xFF, 0x5A with no idle gap -> three Load1 pulses with the correct values and no errors.
